// File: rtl/fft_result_collector.sv
// FFT output collector: captures final-stage vector-unit results, undoes the
// bit-reversed ordering and hands natural-order frames downstream through a two-entry ping-pong buffer.
module fft_result_collector #(
  parameter int formatWidth = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [11:0]                 fft_size,
  input  logic [formatWidth*4-1:0]    vector_output_real_0,
  input  logic [formatWidth*4-1:0]    vector_output_real_1,
  input  logic [formatWidth*4-1:0]    vector_output_real_2,
  input  logic [formatWidth*4-1:0]    vector_output_real_3,
  input  logic [formatWidth*4-1:0]    vector_output_real_4,
  input  logic [formatWidth*4-1:0]    vector_output_real_5,
  input  logic [formatWidth*4-1:0]    vector_output_real_6,
  input  logic [formatWidth*4-1:0]    vector_output_real_7,
  input  logic [formatWidth*4-1:0]    vector_output_imag_0,
  input  logic [formatWidth*4-1:0]    vector_output_imag_1,
  input  logic [formatWidth*4-1:0]    vector_output_imag_2,
  input  logic [formatWidth*4-1:0]    vector_output_imag_3,
  input  logic [formatWidth*4-1:0]    vector_output_imag_4,
  input  logic [formatWidth*4-1:0]    vector_output_imag_5,
  input  logic [formatWidth*4-1:0]    vector_output_imag_6,
  input  logic [formatWidth*4-1:0]    vector_output_imag_7,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [formatWidth*32-1:0]   output_real,
  output logic [formatWidth*32-1:0]   output_imag,
  output logic [11:0]                 out_size,
  output logic                        size_err
);

  localparam int W  = formatWidth;
  localparam int LW = formatWidth * 4;
  localparam int FW = formatWidth * 32;

  logic [LW-1:0] w_lane_re [8];
  logic [LW-1:0] w_lane_im [8];
  logic [W-1:0]  w_samp_re [32];
  logic [W-1:0]  w_samp_im [32];
  logic [W-1:0]  w_slot_re [32];
  logic [W-1:0]  w_slot_im [32];
  logic [FW-1:0] w_frame_re;
  logic [FW-1:0] w_frame_im;

  logic          w_legal;
  logic [2:0]    w_bits;
  logic          w_acc;
  logic          w_wr;
  logic          w_take;

  logic [1:0]    r_cnt;
  logic          r_wp;
  logic          r_rp;
  logic          r_err;
  logic [FW-1:0] r_re   [2];
  logic [FW-1:0] r_im   [2];
  logic [11:0]   r_size [2];

  assign w_lane_re[0] = vector_output_real_0;
  assign w_lane_re[1] = vector_output_real_1;
  assign w_lane_re[2] = vector_output_real_2;
  assign w_lane_re[3] = vector_output_real_3;
  assign w_lane_re[4] = vector_output_real_4;
  assign w_lane_re[5] = vector_output_real_5;
  assign w_lane_re[6] = vector_output_real_6;
  assign w_lane_re[7] = vector_output_real_7;
  assign w_lane_im[0] = vector_output_imag_0;
  assign w_lane_im[1] = vector_output_imag_1;
  assign w_lane_im[2] = vector_output_imag_2;
  assign w_lane_im[3] = vector_output_imag_3;
  assign w_lane_im[4] = vector_output_imag_4;
  assign w_lane_im[5] = vector_output_imag_5;
  assign w_lane_im[6] = vector_output_imag_6;
  assign w_lane_im[7] = vector_output_imag_7;

  // Word j of lane l sits MSB-first and carries intermediate index n = 4l+j.
  for (genvar l = 0; l < 8; l++) begin : g_lane
    for (genvar j = 0; j < 4; j++) begin : g_word
      assign w_samp_re[4*l+j] = w_lane_re[l][LW-1-j*W -: W];
      assign w_samp_im[4*l+j] = w_lane_im[l][LW-1-j*W -: W];
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_pack
    assign w_frame_re[k*W +: W] = w_slot_re[k];
    assign w_frame_im[k*W +: W] = w_slot_im[k];
  end

  function automatic logic [4:0] bitrev(input logic [4:0] n, input logic [2:0] bits);
    logic [4:0] r;
    case (bits)
      3'd5:    r = {n[0], n[1], n[2], n[3], n[4]};
      3'd4:    r = {1'b0, n[0], n[1], n[2], n[3]};
      default: r = {2'b00, n[0], n[1], n[2]};
    endcase
    return r;
  endfunction

  always_comb begin
    w_legal = 1'b1;
    w_bits  = 3'd5;
    case (fft_size)
      12'd32:  w_bits = 3'd5;
      12'd16:  w_bits = 3'd4;
      12'd8:   w_bits = 3'd3;
      default: w_legal = 1'b0;
    endcase
  end

  // Inactive lanes never reach a slot, so slots N..31 keep their zero default.
  always_comb begin : p_scatter
    logic [4:0] v_n;
    for (int unsigned k = 0; k < 32; k++) begin
      w_slot_re[k] = '0;
      w_slot_im[k] = '0;
    end
    for (int unsigned n = 0; n < 32; n++) begin
      v_n = 5'(n);
      if ((v_n >> w_bits) == 5'd0) begin
        w_slot_re[bitrev(v_n, w_bits)] = w_samp_re[v_n];
        w_slot_im[bitrev(v_n, w_bits)] = w_samp_im[v_n];
      end
    end
  end

  assign in_ready = (r_cnt != 2'd2);
  assign w_acc    = in_valid && in_ready;
  assign w_wr     = w_acc && w_legal;
  assign w_take   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_err     <= 1'b0;
      r_re[0]   <= '0;
      r_re[1]   <= '0;
      r_im[0]   <= '0;
      r_im[1]   <= '0;
      r_size[0] <= '0;
      r_size[1] <= '0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_wr) begin
        r_re[r_wp]   <= w_frame_re;
        r_im[r_wp]   <= w_frame_im;
        r_size[r_wp] <= fft_size;
        r_wp         <= ~r_wp;
      end
      if (w_take) begin
        r_rp <= ~r_rp;
      end
      case ({w_wr, w_take})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_valid   = (r_cnt != 2'd0);
  assign output_real = r_re[r_rp];
  assign output_imag = r_im[r_rp];
  assign out_size    = r_size[r_rp];
  assign size_err    = r_err;

endmodule
